multicycle_control: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle opcode decode with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback.
- Shares the single unified memory port between instruction fetch and data access.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeouts.
- Sits between the instruction register (IR) opcode field and the datapath muxes, register file, ALU control and memory.

---
 rtl/multicycle_control.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore sequencer for the multi-cycle MIPS datapath. It steps one instruction
// through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK over a single unified
// memory port. The sequencer waits on the memory ready handshake and traps on
// an undecodable opcode or when a memory access times out.
//
// Parameters:
//   MEM_TIMEOUT   maximum wait cycles held in a memory state before trapping
//                 (0 disables the timeout)
//
// Optional feature macro:
//   MCTRL_JUMP_EN when defined, opcode 0x02 (j) decodes to the JUMP state;
//                 otherwise 0x02 is illegal and traps.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   opcode[5:0]    IR[31:26], valid from the DECODE cycle onward
//   mem_ready      memory completed the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d         memory address select: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   mem_size[1:0]  00 word, 01 half signed, 10 half unsigned
//   ir_write       IR load enable
//   reg_dst        1 = rd, 0 = rt
//   mem_to_reg     1 = MDR to register file
//   reg_write      register file write enable
//   alu_src_a      0 PC, 1 register A
//   alu_src_b[1:0] 00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   alu_op[1:0]    00 add, 01 sub/compare, 10 funct field
//   state[3:0]     current state encoding
//   instr_done     one-cycle pulse on an instruction's final cycle
//   illegal_op     high in TRAP when the cause is an undecodable opcode
//   mem_timeout    high in TRAP when the cause is a memory timeout
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_size,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MCTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t        state_q;
  logic [5:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          trap_illegal;
  logic          mem_state;
  logic          timed_out;

  // Load width follows the latched opcode so the IR may change after DECODE.
  function automatic logic [1:0] load_size(input logic [5:0] op);
    case (op)
      OP_LH:   load_size = 2'b01;
      OP_LHU:  load_size = 2'b10;
      default: load_size = 2'b00;
    endcase
  endfunction

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  // A ready on the same cycle as the limit wins over the timeout.
  assign timed_out = TIMEOUT_EN && mem_state && !mem_ready &&
                     (wait_cnt == TIMEOUT_VAL);

  // State, latched opcode, wait counter and trap cause. The counter runs only
  // while a memory state holds, so any state change clears it on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      wait_cnt     <= '0;
      trap_illegal <= 1'b0;
    end else begin
      if (TIMEOUT_EN && mem_state && !mem_ready && !timed_out)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;

      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (timed_out) begin
            state_q      <= S_TRAP;
            trap_illegal <= 1'b0;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_RTYPE:                   state_q <= S_EXEC_R;
            OP_ADDI:                    state_q <= S_EXEC_I;
            OP_LW, OP_LH, OP_LHU, OP_SW: state_q <= S_MEM_ADDR;
            OP_BEQ:                     state_q <= S_BRANCH;
`ifdef MCTRL_JUMP_EN
            OP_J:                       state_q <= S_JUMP;
`endif
            default: begin
              state_q      <= S_TRAP;
              trap_illegal <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: state_q <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem_ready) begin
            state_q <= S_MEM_WB;
          end else if (timed_out) begin
            state_q      <= S_TRAP;
            trap_illegal <= 1'b0;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            state_q <= S_FETCH;
          end else if (timed_out) begin
            state_q      <= S_TRAP;
            trap_illegal <= 1'b0;
          end
        end
        S_EXEC_R: state_q <= S_R_WB;
        S_EXEC_I: state_q <= S_I_WB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Moore decode of the control word. Outputs are forced low while reset is
  // held so an aborted instruction cannot issue any further writes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_size      = 2'b00;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          mem_size = load_size(op_q);
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          mem_size   = load_size(op_q);
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
`ifdef MCTRL_JUMP_EN
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
`endif
        S_TRAP: begin
          illegal_op  = trap_illegal;
          mem_timeout = !trap_illegal;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control. The driver issues one instruction
// at a time and pushes its expected outcome, computed from the instruction
// class and the planned memory wait counts, into a queue. A memory responder
// answers requests after the planned number of wait cycles, and a monitor
// accumulates what the sequencer did over the instruction and compares it
// with the queued expectation whenever the instruction completes or traps.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TO      = 4;
  localparam int N_RAND  = 250;
  localparam int BUDGET  = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic [1:0] pc_source, mem_size, alu_src_b, alu_op;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .state         (state),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .mem_timeout   (mem_timeout)
  );

  always #5 clk = ~clk;

  // Expected per-instruction outcome. end_vec is {done, illegal, timeout}.
  typedef struct {
    int end_vec;
    int cycles;
    int ir_w;
    int pc_w;
    int pc_cond;
    int reg_w;
    int mem_w;
    int wb_dst;
    int wb_m2r;
    int wb_size;
    int rd_size;
    int br_ctl;
    int j_src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fetch_wait = 0;
  int   data_wait = 0;
  int   done_count = 0;
  int   wc = 0;

  int o_cyc, o_ir, o_pc, o_cond, o_reg, o_memw;
  int o_dst, o_m2r, o_size, o_rsize, o_br, o_jsrc;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: outcome of one instruction from its class and waits.
  function automatic exp_t model(input logic [5:0] op, input int fw, input int dw);
    exp_t e;
    bit   is_load, is_store, jump_ok;
    int   size;
    e = '{default: 0};
`ifdef MCTRL_JUMP_EN
    jump_ok = 1'b1;
`else
    jump_ok = 1'b0;
`endif
    e.end_vec = 4;
    if (fw > TO) begin
      e.end_vec = 1;
      e.cycles  = TO + 2;
      return e;
    end
    e.cycles = fw + 2;
    e.ir_w   = 1;
    e.pc_w   = 1;
    is_load  = op inside {6'h23, 6'h21, 6'h25};
    is_store = (op == 6'h2B);
    size     = (op == 6'h21) ? 1 : (op == 6'h25) ? 2 : 0;
    if (op == 6'h00) begin
      e.cycles += 2; e.reg_w = 1; e.wb_dst = 1;
    end else if (op == 6'h08) begin
      e.cycles += 2; e.reg_w = 1;
    end else if (op == 6'h04) begin
      e.cycles += 1; e.pc_cond = 1; e.br_ctl = 5;
    end else if (jump_ok && op == 6'h02) begin
      e.cycles += 1; e.pc_w = 2; e.j_src = 2;
    end else if (is_load || is_store) begin
      e.cycles += 1;
      if (dw > TO) begin
        e.end_vec = 1;
        e.cycles += TO + 2;
      end else begin
        e.cycles += dw + 1;
        if (is_store) begin
          e.mem_w = 1;
        end else begin
          e.cycles += 1; e.reg_w = 1; e.wb_m2r = 1;
          e.wb_size = size; e.rd_size = size;
        end
      end
    end else begin
      e.end_vec = 2;
      e.cycles += 1;
    end
    return e;
  endfunction

  // Memory responder: answers each request after the planned wait count.
  // Outside a request mem_ready toggles randomly and must be ignored.
  always @(negedge clk) begin
    if (reset) begin
      wc = 0;
      mem_ready = 1'b0;
    end else if (mem_read || mem_write) begin
      if (wc >= (i_or_d ? data_wait : fetch_wait)) begin
        mem_ready = 1'b1;
        wc = 0;
      end else begin
        mem_ready = 1'b0;
        wc++;
      end
    end else begin
      wc = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_obs();
    o_cyc = 0; o_ir = 0; o_pc = 0; o_cond = 0; o_reg = 0; o_memw = 0;
    o_dst = 0; o_m2r = 0; o_size = 0; o_rsize = 0; o_br = 0; o_jsrc = 0;
  endtask

  // Monitor: accumulate activity and score at each instruction end.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      clear_obs();
    end else begin
      o_cyc++;
      o_ir   += int'(ir_write);
      o_pc   += int'(pc_write);
      o_cond += int'(pc_write_cond);
      o_reg  += int'(reg_write);
      if (mem_write && mem_ready) o_memw++;
      if (reg_write) begin
        o_dst = int'(reg_dst); o_m2r = int'(mem_to_reg); o_size = int'(mem_size);
      end
      if (mem_read && i_or_d && mem_ready) o_rsize = int'(mem_size);
      if (pc_write_cond) o_br = int'({alu_op, pc_source});
      if (pc_write && !mem_read) o_jsrc = int'(pc_source);
      if (instr_done || illegal_op || mem_timeout) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_end: got end state=%0d expected no instruction end", state);
        end else begin
          e = exp_q.pop_front();
          check_output("end_cause", int'({instr_done, illegal_op, mem_timeout}), e.end_vec);
          check_output("cycles", o_cyc, e.cycles);
          check_output("ir_write_count", o_ir, e.ir_w);
          check_output("pc_write_count", o_pc, e.pc_w);
          check_output("pc_write_cond_count", o_cond, e.pc_cond);
          check_output("reg_write_count", o_reg, e.reg_w);
          check_output("mem_write_count", o_memw, e.mem_w);
          check_output("wb_reg_dst", o_dst, e.wb_dst);
          check_output("wb_mem_to_reg", o_m2r, e.wb_m2r);
          check_output("wb_mem_size", o_size, e.wb_size);
          check_output("read_mem_size", o_rsize, e.rd_size);
          check_output("branch_ctl", o_br, e.br_ctl);
          check_output("jump_src", o_jsrc, e.j_src);
        end
        clear_obs();
        done_count++;
      end
    end
  end

  function automatic int all_outputs();
    return int'({pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 mem_size, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_op, instr_done, illegal_op, mem_timeout});
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("fetch_state", int'(state), 0);
    check_output("fetch_mem_read", int'(mem_read), 1);
    check_output("fetch_alu_src_b", int'(alu_src_b), 1);
  endtask

  task automatic recover();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // Issue one instruction and wait (bounded) for the monitor to score it.
  // The opcode is only meaningful during DECODE and is scrambled otherwise.
  task automatic apply_stimulus(input logic [5:0] op, input int fw, input int dw);
    int start_done;
    int budget;
    exp_q.push_back(model(op, fw, dw));
    fetch_wait = fw;
    data_wait  = dw;
    start_done = done_count;
    budget     = 0;
    while (done_count == start_done && budget < BUDGET) begin
      @(negedge clk);
      #2;
      budget++;
      if (done_count == start_done) opcode = (state == 4'd1) ? op : 6'($urandom);
    end
    if (done_count == start_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL instr_budget: op=%h got no end after %0d cycles, required end within %0d",
               op, budget, BUDGET);
      recover();
    end
  endtask

  // Abort a load while it waits in MEM_RD and check the asynchronous clear.
  task automatic reset_during_read();
    int budget;
    exp_q.push_back(model(6'h23, 0, 3));
    fetch_wait = 0;
    data_wait  = 3;
    budget     = 0;
    while (state != 4'd3 && budget < BUDGET) begin
      @(negedge clk);
      #2;
      budget++;
      opcode = (state == 4'd1) ? 6'h23 : 6'($urandom);
    end
    check_output("reached_mem_rd", int'(state), 3);
    reset = 1'b1;
    #1;
    check_output("abort_state", int'(state), 0);
    check_output("abort_outputs", all_outputs(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  logic [5:0] op_pool [0:8] = '{6'h00, 6'h08, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h02, 6'h3F};

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return r % 3;
    if (r < 8) return TO;
    return TO + 1;
  endfunction

  initial begin
    logic [5:0] op;
    reset  = 1'b1;
    opcode = 6'h00;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", int'(state), 0);
    check_output("reset_outputs", all_outputs(), 0);
    release_reset();

    apply_stimulus(6'h00, 0, 0);
    apply_stimulus(6'h21, 0, 2);
    apply_stimulus(6'h2B, 0, 0);
    apply_stimulus(6'h04, 0, 0);
    apply_stimulus(6'h3F, 0, 0);
    apply_stimulus(6'h00, TO + 1, 0);
    apply_stimulus(6'h08, TO, 0);
    apply_stimulus(6'h23, 0, TO);
    apply_stimulus(6'h25, 1, TO + 1);
    apply_stimulus(6'h2B, 0, TO + 1);
    apply_stimulus(6'h02, 0, 0);
    apply_stimulus(6'h2B, 2, 3);
    reset_during_read();
    apply_stimulus(6'h25, 0, 0);

    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = op_pool[$urandom_range(0, 8)];
      apply_stimulus(op, rand_wait(), rand_wait());
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
